ex_pipe: RTL

EX_PIPE -- requirements
Module: ex_pipe

---
 rtl/ex_pkg.sv | 27 ++
 rtl/ex_mul_iter.sv | 68 ++++++
 rtl/ex_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcodes, FSM states and saturation constants for ex_pipe
package ex_pkg;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_SUB = 3'd1,
    FN_AND = 3'd2,
    FN_NOR = 3'd3,
    FN_SLL = 3'd4,
    FN_SRL = 3'd5,
    FN_SRA = 3'd6,
    FN_MUL = 3'd7
  } func_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Widest legal saturation value; ex_pipe narrows it to WIDTH.
  localparam logic [63:0] SAT_POS64 = 64'h7FFF_FFFF_FFFF_FFFF;

  function automatic logic is_arith(input func_e f);
    return (f == FN_ADD) || (f == FN_SUB);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done     = 1'b0;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  // The final partial sum is handed out combinationally so the result lands on the done edge.
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/ex_pipe.sv
// rtl/ex_pipe.sv - single-stage execute unit: saturating ALU, shifter, iterative MUL, alternate-PC
module ex_pipe
  import ex_pkg::*;
#(
  parameter int  WIDTH   = 16,
  parameter int  IMM_W   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         func,
  input  logic               src1sel,
  input  logic [WIDTH-1:0]   p0,
  input  logic [WIDTH-1:0]   p1,
  input  logic [IMM_W-1:0]   imm,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   pc,
  input  logic [IMM_W-1:0]   br_off,
  input  logic               jr_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dst,
  output logic [WIDTH-1:0]   sdata,
  output logic [WIDTH-1:0]   alt_pc,
  output logic [2:0]         flags
);

  localparam int             MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(SAT_POS64 >> (64 - WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] sdata_q, sdata_d;
  logic [WIDTH-1:0] alt_pc_q, alt_pc_d;
  logic [2:0]       flags_q, flags_d;

  func_e                   fn;
  logic                    accept, mul_start, mul_done;
  logic [WIDTH-1:0]        mul_product;
  logic signed [WIDTH-1:0] imm_sx, off_sx;
  logic [WIDTH-1:0]        src1, sum, diff, alu_res;
  logic                    alu_v;

  assign imm_sx    = WIDTH'($signed(imm));
  assign off_sx    = WIDTH'($signed(br_off));
  assign src1      = src1sel ? imm_sx : p1;
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (fn == FN_MUL);

  always_comb begin
    fn      = func_e'(func);
    sum     = p0 + src1;
    diff    = p0 - src1;
    alu_res = '0;
    alu_v   = 1'b0;
    case (fn)
      FN_ADD: begin
        alu_v   = (p0[MSB] == src1[MSB]) && (sum[MSB] != p0[MSB]);
        alu_res = alu_v ? (p0[MSB] ? SAT_NEG : SAT_POS) : sum;
      end
      FN_SUB: begin
        alu_v   = (p0[MSB] != src1[MSB]) && (diff[MSB] != p0[MSB]);
        alu_res = alu_v ? (p0[MSB] ? SAT_NEG : SAT_POS) : diff;
      end
      FN_AND:  alu_res = p0 & src1;
      FN_NOR:  alu_res = ~(p0 | src1);
      FN_SLL:  alu_res = p0 << shamt;
      FN_SRL:  alu_res = p0 >> shamt;
      FN_SRA:  alu_res = $signed(p0) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  ex_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (p0),
    .b      (src1),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    dst_d       = dst_q;
    sdata_d     = sdata_q;
    alt_pc_d    = alt_pc_q;
    flags_d     = flags_q;
    if (accept) begin
      sdata_d  = p1;
      alt_pc_d = jr_sel ? p0 : (pc + off_sx);
      if (mul_start) begin
        state_d = ST_MUL;
      end else begin
        dst_d       = alu_res;
        out_valid_d = 1'b1;
        flags_d[1]  = (alu_res == '0);
        if (is_arith(fn)) begin
          flags_d[2] = alu_res[MSB];
          flags_d[0] = alu_v;
        end
      end
    end
    // Nothing can be accepted while in MUL, so the result path never collides with accept.
    if ((state_q == ST_MUL) && mul_done) begin
      state_d     = ST_IDLE;
      dst_d       = mul_product;
      out_valid_d = 1'b1;
      flags_d[1]  = (mul_product == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      dst_q       <= '0;
      sdata_q     <= '0;
      alt_pc_q    <= '0;
      flags_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      dst_q       <= dst_d;
      sdata_q     <= sdata_d;
      alt_pc_q    <= alt_pc_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dst       = dst_q;
  assign sdata     = sdata_q;
  assign alt_pc    = alt_pc_q;
  assign flags     = flags_q;

endmodule
